mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Main control FSM for the multicycle variant of the MIPS core.
- Sequences a shared-ALU datapath with a single unified memory through Fetch/Decode/Execute/Memory/Writeback steps.
- Consumes decoded opcode/funct from the existing decoder and the ALU zero flag.
- Stalls on a memory-ready handshake and drives all datapath mux selects and write enables.

Parameters:
- STATE_W, 4, width of the exported state code.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- op  input  6  instruction opcode field [31:26]
- funct  input  6  instruction funct field [5:0]
- zero  input  1  ALU result == 0
- mem_ready  input  1  unified memory has completed the current access
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- reg_dst  output  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  output  1  writeback select: 0 = ALUOut, 1 = Data register
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0 = PC, 1 = rs
- alu_src_b  output  2  00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- alu_ctrl  output  3  ALU operation code
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  output  1  PC register load
- instr_done  output  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  output  1  one-cycle pulse on an unsupported opcode/funct
- state  output  STATE_W  current state code, for debug

Behaviour:
- Clock and reset: single clock, clk; reset is synchronous and active-high.
- Reset:
  - state <= FETCH (code 0).
  - While reset is high, all strobes (mem_write, ir_write, reg_write, pc_en, instr_done, illegal_op) are forced to 0.
  - Selects take their FETCH values.
- Output timing: Moore outputs decoded from state, except pc_en and the memory-gated strobes, which are combinational.
- Default output values: all strobes 0, selects 0, alu_ctrl = 010 (add).
- pc_en = pc_write | (branch_cond & zero).
- States, codes and transitions:
  - FETCH (0):
    - iord = 0, alu_src_a = 0, alu_src_b = 01, alu_ctrl = 010, pc_src = 00.
    - ir_write and pc_write are asserted only when mem_ready = 1.
    - Moves to DECODE when mem_ready = 1, otherwise holds.
  - DECODE (1):
    - alu_src_a = 0, alu_src_b = 11, alu_ctrl = 010 (branch target precompute).
    - Next state by op: lw 100011 / sw 101011 -> MEMADR; R 000000 -> EXECUTE; beq 000100 -> BRANCH; addi 001000 -> ADDIEX; j 000010 -> JUMP.
    - Any other op: illegal_op = 1, instr_done = 1, next FETCH.
  - MEMADR (2): alu_src_a = 1, alu_src_b = 10, alu_ctrl = 010; lw -> MEMRD, sw -> MEMWR.
  - MEMRD (3): iord = 1; -> MEMWB when mem_ready = 1, else holds.
  - MEMWB (4): reg_dst = 0, mem_to_reg = 1, reg_write = 1, instr_done = 1; -> FETCH.
  - MEMWR (5):
    - iord = 1; mem_write is asserted every cycle in this state.
    - When mem_ready = 1: instr_done = 1, -> FETCH.
  - EXECUTE (6):
    - alu_src_a = 1, alu_src_b = 00.
    - alu_ctrl by funct: add 100000 -> 010, sub 100010 -> 110, and 100100 -> 000, or 100101 -> 001, slt 101010 -> 111.
    - Supported funct -> ALUWB.
    - Unsupported funct: illegal_op = 1, instr_done = 1, -> FETCH with no register write.
  - ALUWB (7): reg_dst = 1, mem_to_reg = 0, reg_write = 1, instr_done = 1; -> FETCH.
  - BRANCH (8):
    - alu_src_a = 1, alu_src_b = 00, alu_ctrl = 110, pc_src = 01, branch_cond = 1, instr_done = 1; -> FETCH.
  - ADDIEX (9): alu_src_a = 1, alu_src_b = 10, alu_ctrl = 010; -> ADDIWB.
  - ADDIWB (10): reg_dst = 0, mem_to_reg = 0, reg_write = 1, instr_done = 1; -> FETCH.
  - JUMP (11): pc_src = 10, pc_write = 1, instr_done = 1; -> FETCH.
  - Codes 12-15: unreachable; if entered, -> FETCH with all strobes 0.
- Latency with mem_ready held at 1: R = 4 cycles, lw = 5, sw = 4, beq = 3, addi = 4, j = 3. Each low cycle of mem_ready in FETCH, MEMRD or MEMWR adds one cycle.
- Reset asserted mid-instruction: state is FETCH on the next cycle; no partial writeback is issued.
- mem_ready is ignored in states that make no memory access.

Optional Feature:
- Macro: MC_BNE_EN.
- Defined: op 000101 (bne) in DECODE -> BRANCH with branch_cond inverted, so pc_en = pc_write | (branch_cond & ~zero) for bne. Latency is 3 cycles.
- Undefined: op 000101 is an unsupported opcode and pulses illegal_op in DECODE.

Test Plan:
- Reset and R-type add: assert reset for 2 cycles, release; op = 000000, funct = 100000, mem_ready = 1 -> states 0,1,6,7; alu_ctrl = 010 in state 6; reg_write = 1 and instr_done = 1 in state 7 only.
- lw with memory stalls: op = 100011, mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD -> total 10 cycles; ir_write asserted exactly once; iord = 1 throughout MEMRD; mem_to_reg = 1 and reg_write = 1 in MEMWB.
- beq: op = 000100 with zero = 1 in BRANCH -> pc_en = 1 and pc_src = 01; with zero = 0 -> pc_en = 0; both complete in 3 cycles.
- sw, j and addi: sw -> mem_write high only in state 5 and no reg_write; j -> pc_src = 10 and pc_en = 1 in state 11; addi -> reg_dst = 0 and reg_write in state 10.
- Illegal opcode and funct: op = 111111 -> illegal_op pulse in DECODE, back to FETCH next cycle; R-type with funct = 000000 -> illegal_op in EXECUTE and no reg_write. With MC_BNE_EN defined: op = 000101, zero = 0 -> pc_en = 1.
- Reset mid-lw: assert reset while in MEMRD -> state = 0 next cycle; reg_write and mem_write never asserted.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback over a shared ALU and unified memory.
// Latency: R=4, lw=5, sw=4, beq=3, addi=4, j=3 cycles with mem_ready high; each low mem_ready cycle in FETCH/MEMRD/MEMWR adds one.
// Backpressure: holds in FETCH, MEMRD and MEMWR until mem_ready; optional bne support via `define MC_BNE_EN.
module mc_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_ctrl,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  state_t cur;
  state_t nxt;
  state_t eff;
  logic   pc_write;
  logic   branch_cond;
  logic   branch_take;

  // Branch taken condition: bne (when enabled) branches on a non-zero compare.
  // The IR holds op stable for the whole instruction, so op is valid in BRANCH.
`ifdef MC_BNE_EN
  assign branch_take = (op == OP_BNE) ? ~zero : zero;
`else
  assign branch_take = zero;
`endif

  assign pc_en = pc_write | (branch_cond & branch_take);
  assign state = STATE_W'(cur);

  // State register; reset returns to FETCH on the next edge.
  always_ff @(posedge clk) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  // Next-state and output decode; while reset is high the FETCH selects are shown with every strobe held low.
  always_comb begin
    eff         = reset ? S_FETCH : cur;
    nxt         = S_FETCH;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_ctrl    = 3'b010;
    pc_src      = 2'b00;
    pc_write    = 1'b0;
    branch_cond = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;

    case (eff)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        nxt       = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECUTE;
          OP_BEQ:       nxt = S_BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       nxt = S_BRANCH;
`endif
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        nxt  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        nxt        = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        nxt       = S_ALUWB;
        case (funct)
          6'b100000: alu_ctrl = 3'b010;
          6'b100010: alu_ctrl = 3'b110;
          6'b100100: alu_ctrl = 3'b000;
          6'b100101: alu_ctrl = 3'b001;
          6'b101010: alu_ctrl = 3'b111;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_ctrl    = 3'b110;
        pc_src      = 2'b01;
        branch_cond = 1'b1;
        instr_done  = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase

    if (reset) begin
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      pc_write    = 1'b0;
      branch_cond = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class cycle by cycle against hand-computed output vectors.
// Inputs change 1 ns after the rising edge; outputs are sampled 4 ns after the edge.
// Supports builds with or without MC_BNE_EN.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [1:0] pc_src;
  logic       pc_en, instr_done, illegal_op;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;
  int irw_cnt  = 0;
  int bad_wr   = 0;
  bit irw_en   = 0;
  bit watch    = 0;

  logic [16:0] o_rst, o_f1, o_dec, o_dec_ill, o_ma, o_mr, o_mwb, o_mw0, o_mw1;
  logic [16:0] o_ex_ill, o_awb, o_aiwb, o_j;

  mc_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src), .pc_en(pc_en),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  wire [16:0] outs = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                      alu_src_b, alu_ctrl, pc_src, pc_en, instr_done, illegal_op};

  // Side monitors: count ir_write pulses and any register/memory write in a watched window.
  always @(negedge clk) begin
    if (irw_en && ir_write) irw_cnt++;
    if (watch && (reg_write || mem_write)) bad_wr++;
  end

  function automatic logic [16:0] ov(input logic io, input logic mw, input logic irw, input logic rd,
                                     input logic m2r, input logic rw, input logic asa,
                                     input logic [1:0] asb, input logic [2:0] alu,
                                     input logic [1:0] pcs, input logic pce, input logic dn,
                                     input logic il);
    return {io, mw, irw, rd, m2r, rw, asa, asb, alu, pcs, pce, dn, il};
  endfunction

  function automatic logic [16:0] ex(input logic [2:0] alu);
    return ov(0, 0, 0, 0, 0, 0, 1, 2'b00, alu, 2'b00, 0, 0, 0);
  endfunction

  function automatic logic [16:0] br(input logic pce);
    return ov(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, pce, 1, 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle: check state and outputs mid-cycle, then advance to 1 ns after the next edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] o);
    #3;
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_outs"}, 32'(outs), 32'(o));
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fn_tab  [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] alu_tab [4] = '{3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    o_rst     = ov(0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0, 0, 0);
    o_f1      = ov(0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 1, 0, 0);
    o_dec     = ov(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 0, 0);
    o_dec_ill = ov(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 1, 1);
    o_ma      = ov(0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 0);
    o_mr      = ov(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 0);
    o_mwb     = ov(0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b010, 2'b00, 0, 1, 0);
    o_mw0     = ov(1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 0);
    o_mw1     = ov(1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 1, 0);
    o_ex_ill  = ov(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 2'b00, 0, 1, 1);
    o_awb     = ov(0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0, 1, 0);
    o_aiwb    = ov(0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0, 1, 0);
    o_j       = ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b10, 1, 1, 0);

    reset = 1'b1; op = 6'b000000; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("rst0", 4'd0, o_rst);
    cyc("rst1", 4'd0, o_rst);
    reset = 1'b0;

    // R-type add, then the remaining supported functs
    cyc("add_f", 4'd0, o_f1);
    cyc("add_d", 4'd1, o_dec);
    cyc("add_e", 4'd6, ex(3'b010));
    cyc("add_w", 4'd7, o_awb);
    for (int i = 0; i < 4; i++) begin
      funct = fn_tab[i];
      cyc("r_f", 4'd0, o_f1);
      cyc("r_d", 4'd1, o_dec);
      cyc("r_e", 4'd6, ex(alu_tab[i]));
      cyc("r_w", 4'd7, o_awb);
    end

    // lw with 2 FETCH stalls and 3 MEMRD stalls: 10 cycles
    op = 6'b100011; mem_ready = 1'b0; irw_en = 1;
    cyc("lw_f0a", 4'd0, o_rst);
    cyc("lw_f0b", 4'd0, o_rst);
    mem_ready = 1'b1;
    cyc("lw_f1", 4'd0, o_f1);
    cyc("lw_d", 4'd1, o_dec);
    cyc("lw_ma", 4'd2, o_ma);
    mem_ready = 1'b0;
    cyc("lw_mr0", 4'd3, o_mr);
    cyc("lw_mr1", 4'd3, o_mr);
    cyc("lw_mr2", 4'd3, o_mr);
    mem_ready = 1'b1;
    cyc("lw_mr3", 4'd3, o_mr);
    cyc("lw_wb", 4'd4, o_mwb);
    irw_en = 0;
    check("lw_irw_cnt", 32'(irw_cnt), 32'd1);

    // beq taken / not taken
    op = 6'b000100; zero = 1'b1;
    cyc("beq1_f", 4'd0, o_f1);
    cyc("beq1_d", 4'd1, o_dec);
    cyc("beq1_b", 4'd8, br(1'b1));
    zero = 1'b0;
    cyc("beq0_f", 4'd0, o_f1);
    cyc("beq0_d", 4'd1, o_dec);
    cyc("beq0_b", 4'd8, br(1'b0));

    // sw with one stall in MEMWR
    op = 6'b101011;
    cyc("sw_f", 4'd0, o_f1);
    cyc("sw_d", 4'd1, o_dec);
    cyc("sw_ma", 4'd2, o_ma);
    mem_ready = 1'b0;
    cyc("sw_mw0", 4'd5, o_mw0);
    mem_ready = 1'b1;
    cyc("sw_mw1", 4'd5, o_mw1);

    // j
    op = 6'b000010;
    cyc("j_f", 4'd0, o_f1);
    cyc("j_d", 4'd1, o_dec);
    cyc("j_j", 4'd11, o_j);

    // addi
    op = 6'b001000;
    cyc("addi_f", 4'd0, o_f1);
    cyc("addi_d", 4'd1, o_dec);
    cyc("addi_ex", 4'd9, o_ma);
    cyc("addi_wb", 4'd10, o_aiwb);

    // illegal opcode, then illegal funct
    op = 6'b111111;
    cyc("ill_op_f", 4'd0, o_f1);
    cyc("ill_op_d", 4'd1, o_dec_ill);
    op = 6'b000000; funct = 6'b000000;
    cyc("ill_fn_f", 4'd0, o_f1);
    cyc("ill_fn_d", 4'd1, o_dec);
    cyc("ill_fn_e", 4'd6, o_ex_ill);

    // bne with zero = 0
    op = 6'b000101; zero = 1'b0;
    cyc("bne_f", 4'd0, o_f1);
`ifdef MC_BNE_EN
    cyc("bne_d", 4'd1, o_dec);
    cyc("bne_b", 4'd8, br(1'b1));
`else
    cyc("bne_d", 4'd1, o_dec_ill);
`endif

    // reset asserted while lw waits in MEMRD
    op = 6'b100011; watch = 1;
    cyc("rlw_f", 4'd0, o_f1);
    cyc("rlw_d", 4'd1, o_dec);
    cyc("rlw_ma", 4'd2, o_ma);
    mem_ready = 1'b0;
    cyc("rlw_mr", 4'd3, o_mr);
    reset = 1'b1;
    cyc("rlw_rst", 4'd3, o_rst);
    reset = 1'b0; mem_ready = 1'b1;
    cyc("rlw_after", 4'd0, o_f1);
    watch = 0;
    check("rlw_no_write", 32'(bad_wr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
